pll_reset_sequencer: RTL

Supervises the ECP5 EHXPLLL that generates the 125/250/25/83.333 MHz HDMI clocks. It pulses the PLL's RST input and waits for LOCK, retrying on timeout. It holds the downstream reset until lock has been stable for a programmable time, and re-sequences on any lock loss. It runs only on the free-running 25 MHz board oscillator, never on a PLL output, so it keeps working while the PLL is unlocked.

---
 rtl/pll_reset_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - ECP5 PLL reset/lock supervisor with stable-lock gated downstream reset
//
// Runs only on the free-running board oscillator, so it keeps sequencing while the PLL is unlocked.
// Ports:
//   clkin_25MHz     in   board oscillator, the only clock
//   reset           in   asynchronous active-high reset
//   locked          in   PLL LOCK, asynchronous (synchronized internally)
//   restart         in   single-cycle request to re-run the whole sequence
//   pll_rst         out  PLL RST drive, active-high
//   periph_rst      out  downstream reset, active-high (consumers synchronize release locally)
//   ready           out  high only in RUN
//   state           out  0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//   retry_count     out  lock-timeout retries, saturating at 255
//   lock_loss_count out  lock drops seen in RUN, saturating at 255
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 250000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int CNT_W               = 18
) (
  input  logic       clkin_25MHz,
  input  logic       reset,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       periph_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam logic [1:0] S_RESET_PLL = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_STABLE    = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pll_rst;
  logic             r_periph_rst;
  logic             r_ready;
  logic [7:0]       r_retry_count;
  logic [7:0]       r_lock_loss_count;

  logic [1:0]       w_next_state;
  logic             w_enter;
  logic             w_retry_inc;
  logic             w_loss_inc;

  // restart overrides every other transition and suppresses both event counters.
  always_comb begin
    w_next_state = r_state;
    w_retry_inc  = 1'b0;
    w_loss_inc   = 1'b0;
    if (restart) begin
      w_next_state = S_RESET_PLL;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == RST_LAST) w_next_state = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (r_sync2) begin
            w_next_state = S_STABLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_next_state = S_RESET_PLL;
            w_retry_inc  = 1'b1;
          end
        end
        S_STABLE: begin
          // A lock glitch only restarts the stability window; the PLL is not reset.
          if (!r_sync2) begin
            w_next_state = S_WAIT_LOCK;
          end else if (r_cnt == STABLE_LAST) begin
            w_next_state = S_RUN;
          end
        end
        S_RUN: begin
          if (!r_sync2) begin
            w_next_state = S_RESET_PLL;
            w_loss_inc   = 1'b1;
          end
        end
        default: w_next_state = S_RESET_PLL;
      endcase
    end
  end

  // restart re-enters RESET_PLL even from RESET_PLL, so it must also clear the counter.
  assign w_enter = restart || (w_next_state != r_state);

  always_ff @(posedge clkin_25MHz or posedge reset) begin
    if (reset) begin
      r_sync1           <= 1'b0;
      r_sync2           <= 1'b0;
      r_state           <= S_RESET_PLL;
      r_cnt             <= '0;
      r_pll_rst         <= 1'b1;
      r_periph_rst      <= 1'b1;
      r_ready           <= 1'b0;
      r_retry_count     <= 8'd0;
      r_lock_loss_count <= 8'd0;
    end else begin
      r_sync1 <= locked;
      r_sync2 <= r_sync1;
      r_state <= w_next_state;

      // The counter is idle in RUN so it never wraps while the system runs.
      if (w_enter) begin
        r_cnt <= '0;
      end else if (r_state != S_RUN) begin
        r_cnt <= r_cnt + CNT_ONE;
      end

      // Outputs decode the next state so they move on the same edge as state.
      r_pll_rst    <= (w_next_state == S_RESET_PLL);
      r_periph_rst <= (w_next_state != S_RUN);
      r_ready      <= (w_next_state == S_RUN);

      if (w_retry_inc && (r_retry_count != 8'hFF)) begin
        r_retry_count <= r_retry_count + 8'd1;
      end
      if (w_loss_inc && (r_lock_loss_count != 8'hFF)) begin
        r_lock_loss_count <= r_lock_loss_count + 8'd1;
      end
    end
  end

  assign pll_rst         = r_pll_rst;
  assign periph_rst      = r_periph_rst;
  assign ready           = r_ready;
  assign state           = r_state;
  assign retry_count     = r_retry_count;
  assign lock_loss_count = r_lock_loss_count;

endmodule
